alu_op_sequencer: RTL

//  Command-driven controller for cpu_top (8x16 register file + 74181 ALU datapath).

---
 rtl/alu_op_sequencer_if.sv | 47 ++++
 rtl/alu_op_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer_if
// Host-side command/response bundle for alu_op_sequencer.
//   master : host / test driver (drives the command, observes the response)
//   slave  : the sequencer
// Command : cmd_valid/cmd_ready handshake plus the operation fields
//           (load, comm, mode, cin, use_carry, bsel, wb, ra, rb, rd, imm).
// Response: rsp_valid pulse, rsp_result, carry_flag, zero_flag.
// DATA_WIDTH / NUM_REGS must match the parameters of the connected sequencer.
// ----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_load;
    logic [3:0]            cmd_comm;
    logic                  cmd_mode;
    logic                  cmd_cin;
    logic                  cmd_use_carry;
    logic                  cmd_bsel;
    logic                  cmd_wb;
    logic [ADDR_WIDTH-1:0] cmd_ra;
    logic [ADDR_WIDTH-1:0] cmd_rb;
    logic [ADDR_WIDTH-1:0] cmd_rd;
    logic [DATA_WIDTH-1:0] cmd_imm;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  carry_flag;
    logic                  zero_flag;

    modport master (
        output cmd_valid, cmd_load, cmd_comm, cmd_mode, cmd_cin, cmd_use_carry,
               cmd_bsel, cmd_wb, cmd_ra, cmd_rb, cmd_rd, cmd_imm,
        input  cmd_ready, rsp_valid, rsp_result, carry_flag, zero_flag
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_comm, cmd_mode, cmd_cin, cmd_use_carry,
               cmd_bsel, cmd_wb, cmd_ra, cmd_rb, cmd_rd, cmd_imm,
        output cmd_ready, rsp_valid, rsp_result, carry_flag, zero_flag
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
// Command-driven controller for cpu_top (register file + 74181 ALU datapath).
// One command per handshake, sequenced IDLE -> EXEC -> WB (LOAD: IDLE -> WB).
//
// Ports
//   clk, reset_n        clock; synchronous active-low reset
//   host (slave)        command handshake + response (alu_op_sequencer_if)
//   reg_write_enable,
//   reg_read_addr1/2,
//   reg_write_addr,
//   reg_write_data      register file controls to cpu_top
//   alu_comm, alu_mode,
//   alu_cin,
//   b_source_sel,
//   alu_b_imm           ALU controls to cpu_top
//   alu_result,
//   alu_cout            ALU outputs from cpu_top (combinational)
//
// Build option
//   SEQ_CARRY_CHAIN_EN  when defined, cmd_use_carry selects the stored
//                       carry flag as alu_cin (multi-word add chaining);
//                       otherwise alu_cin is always cmd_cin.
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_REGS   = 8,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_op_sequencer_if.slave     host,
    output logic                  reg_write_enable,
    output logic [ADDR_WIDTH-1:0] reg_read_addr1,
    output logic [ADDR_WIDTH-1:0] reg_read_addr2,
    output logic [ADDR_WIDTH-1:0] reg_write_addr,
    output logic [DATA_WIDTH-1:0] reg_write_data,
    output logic [3:0]            alu_comm,
    output logic                  alu_mode,
    output logic                  alu_cin,
    output logic                  b_source_sel,
    output logic [DATA_WIDTH-1:0] alu_b_imm,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_cout
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    // cin holds the effective carry-in, resolved at acceptance so it stays
    // stable through WB even though carry_flag updates at the EXEC edge.
    typedef struct packed {
        logic                  load;
        logic [3:0]            comm;
        logic                  mode;
        logic                  cin;
        logic                  bsel;
        logic                  wb;
        logic [ADDR_WIDTH-1:0] ra;
        logic [ADDR_WIDTH-1:0] rb;
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] imm;
    } cmd_t;

    state_t                state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  carry_q, carry_d;
    logic                  zero_q, zero_d;
    logic                  sel_cin;
    logic                  alu_on;

`ifdef SEQ_CARRY_CHAIN_EN
    assign sel_cin = host.cmd_use_carry ? carry_q : host.cmd_cin;
`else
    logic unused_use_carry;
    assign unused_use_carry = host.cmd_use_carry;
    assign sel_cin          = host.cmd_cin;
`endif

    // ALU controls are live in EXEC and held through WB; a LOAD never uses them.
    assign alu_on = (state_q == EXEC) || (state_q == WB && !cmd_q.load);

    always_comb begin
        state_d          = state_q;
        cmd_d            = cmd_q;
        result_d         = result_q;
        carry_d          = carry_q;
        zero_d           = zero_q;
        host.cmd_ready   = 1'b0;
        host.rsp_valid   = 1'b0;
        reg_write_enable = 1'b0;
        reg_write_addr   = '0;
        reg_write_data   = '0;
        reg_read_addr1   = '0;
        reg_read_addr2   = '0;
        alu_comm         = '0;
        alu_mode         = 1'b0;
        alu_cin          = 1'b0;
        b_source_sel     = 1'b0;
        alu_b_imm        = '0;

        if (alu_on) begin
            reg_read_addr1 = cmd_q.ra;
            reg_read_addr2 = cmd_q.rb;
            alu_comm       = cmd_q.comm;
            alu_mode       = cmd_q.mode;
            alu_cin        = cmd_q.cin;
            b_source_sel   = cmd_q.bsel;
            alu_b_imm      = cmd_q.imm;
        end

        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so nothing is offered
                // until the first cycle after release.
                host.cmd_ready = reset_n;
                if (host.cmd_valid && reset_n) begin
                    cmd_d.load = host.cmd_load;
                    cmd_d.comm = host.cmd_comm;
                    cmd_d.mode = host.cmd_mode;
                    cmd_d.cin  = sel_cin;
                    cmd_d.bsel = host.cmd_bsel;
                    cmd_d.wb   = host.cmd_wb;
                    cmd_d.ra   = host.cmd_ra;
                    cmd_d.rb   = host.cmd_rb;
                    cmd_d.rd   = host.cmd_rd;
                    cmd_d.imm  = host.cmd_imm;
                    if (host.cmd_load) begin
                        // LOAD result is known now; carry flag is left alone.
                        result_d = host.cmd_imm;
                        zero_d   = (host.cmd_imm == '0);
                        state_d  = WB;
                    end else begin
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                result_d = alu_result;
                carry_d  = alu_cout;
                zero_d   = (alu_result == '0);
                state_d  = WB;
            end
            WB: begin
                // Gated by reset_n so a reset landing on WB drops the write.
                reg_write_enable = (cmd_q.wb || cmd_q.load) && reset_n;
                reg_write_addr   = cmd_q.rd;
                reg_write_data   = result_q;
                host.rsp_valid   = reset_n;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign host.rsp_result = result_q;
    assign host.carry_flag = carry_q;
    assign host.zero_flag  = zero_q;

endmodule
